// File: rtl/fpga_text_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fpga_text_ram_arbiter_pkg
// Shared definitions for the text RAM arbiter: RAM address width, the blank
// cell value returned for off-screen fetches, and the arbiter state encoding.
// ---------------------------------------------------------------------------
package fpga_text_ram_arbiter_pkg;

    localparam int ADDR_W = 12;

    // Space character (8'h20) with a zero attribute.
    localparam logic [15:0] BLANK_CELL = 16'h0020;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fpga_text_ram_arbiter_addr_calc.sv
// ---------------------------------------------------------------------------
// fpga_text_ram_arbiter_addr_calc
// Combinational cell-coordinate to linear-address converter.
// Ports:
//   x, y      : cell column / row, 8'hFF marks a blank (off-screen) cell
//   addr      : linear cell address y*COLS + x (12 bits, truncated)
//   in_range  : high when the cell lies on screen and may touch the RAM
// ---------------------------------------------------------------------------
module fpga_text_ram_arbiter_addr_calc
    import fpga_text_ram_arbiter_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    output logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    localparam logic [7:0]        COLS_B = 8'(COLS);
    localparam logic [7:0]        ROWS_B = 8'(ROWS);
    localparam logic [ADDR_W-1:0] COLS_W = ADDR_W'(COLS);

    logic [ADDR_W-1:0] x_w;
    logic [ADDR_W-1:0] y_w;

    assign x_w = {{(ADDR_W-8){1'b0}}, x};
    assign y_w = {{(ADDR_W-8){1'b0}}, y};

    // 80 columns = 64 + 16, so the standard geometry needs no multiplier.
    generate
        if (COLS == 80) begin : g_shift_add
            assign addr = (y_w << 6) + (y_w << 4) + x_w;
        end else begin : g_mult
            assign addr = y_w * COLS_W + x_w;
        end
    endgenerate

    assign in_range = (x != 8'hFF) && (y != 8'hFF) && (x < COLS_B) && (y < ROWS_B);

endmodule

// File: rtl/fpga_text_ram_arbiter.sv
// ---------------------------------------------------------------------------
// fpga_text_ram_arbiter
// Shares one single-port synchronous text RAM between the video fetch path,
// a whole-screen fill engine and a host access port. One RAM access per
// cycle; priority video > fill > host.
// Ports:
//   clk, rst_n                   : pixel clock, async active-low reset
//   vid_req, vid_x, vid_y        : per-cell video fetch request
//   vid_valid, vid_char, vid_attr: fetched cell, two cycles after request
//   host_req/we/addr/wdata       : host access (level request)
//   host_ack/err/rdata           : completion pulse, range error, read data
//   clear, fill, busy            : screen fill start, fill value, fill status
//   ram_addr/we/wdata/rdata      : RAM port, read data valid cycle after addr
// ---------------------------------------------------------------------------
module fpga_text_ram_arbiter
    import fpga_text_ram_arbiter_pkg::*;
#(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int DEPTH = COLS * ROWS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [7:0]        vid_x,
    input  logic [7:0]        vid_y,
    output logic              vid_valid,
    output logic [7:0]        vid_char,
    output logic [7:0]        vid_attr,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_wdata,
    output logic              host_ack,
    output logic              host_err,
    output logic [15:0]       host_rdata,
    input  logic              clear,
    input  logic [15:0]       fill,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    arb_state_t        state;
    logic [ADDR_W-1:0] fill_cnt;
    logic [15:0]       fill_val;
    logic [ADDR_W-1:0] ram_addr_q;

    logic [ADDR_W-1:0] vid_addr;
    logic              vid_in_range;
    logic              vid_take;
    logic              fill_take;
    logic              host_inflight;
    logic              host_grant;
    logic              host_bad;
    logic              host_take;

    logic              v1_valid;
    logic              v1_blank;
    logic              h1_valid;
    logic              h1_we;
    logic              h1_err;

    fpga_text_ram_arbiter_addr_calc #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_addr_calc (
        .x        (vid_x),
        .y        (vid_y),
        .addr     (vid_addr),
        .in_range (vid_in_range)
    );

    // An off-screen video request needs no RAM, so it leaves the slot free.
    assign vid_take      = vid_req && vid_in_range;
    assign fill_take     = (state == ST_FILL) && !vid_take;
    assign host_inflight = h1_valid || host_ack;
    assign host_grant    = host_req && !vid_take && (state == ST_IDLE) && !host_inflight;
    assign host_bad      = {1'b0, host_addr} >= DEPTH_X;
    assign host_take     = host_grant && !host_bad;

    // RAM port mux; with no access the address stays where it was.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ram_addr_q;
        ram_wdata = fill_val;
        if (vid_take) begin
            ram_addr = vid_addr;
        end else if (fill_take) begin
            ram_we   = 1'b1;
            ram_addr = fill_cnt;
        end else if (host_take) begin
            ram_we    = host_we;
            ram_addr  = host_addr;
            ram_wdata = host_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q <= '0;
        end else begin
            ram_addr_q <= ram_addr;
        end
    end

    // Fill engine: one cell per cycle the video path leaves free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            fill_cnt <= '0;
            fill_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state    <= ST_FILL;
                        busy     <= 1'b1;
                        fill_cnt <= '0;
                        fill_val <= fill;
                    end
                end
                ST_FILL: begin
                    if (fill_take) begin
                        if (fill_cnt == LAST_CELL) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            fill_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Video return path: RAM data lands the cycle after the address, and is
    // registered into the output one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_valid  <= 1'b0;
            v1_blank  <= 1'b0;
            vid_valid <= 1'b0;
            vid_char  <= BLANK_CELL[7:0];
            vid_attr  <= BLANK_CELL[15:8];
        end else begin
            v1_valid  <= vid_req;
            v1_blank  <= !vid_in_range;
            vid_valid <= v1_valid;
            if (v1_valid) begin
                vid_char <= v1_blank ? BLANK_CELL[7:0]  : ram_rdata[7:0];
                vid_attr <= v1_blank ? BLANK_CELL[15:8] : ram_rdata[15:8];
            end
        end
    end

    // Host return path; writes leave the read data register untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_valid   <= 1'b0;
            h1_we      <= 1'b0;
            h1_err     <= 1'b0;
            host_ack   <= 1'b0;
            host_err   <= 1'b0;
            host_rdata <= '0;
        end else begin
            h1_valid <= host_grant;
            h1_we    <= host_we;
            h1_err   <= host_bad;
            host_ack <= h1_valid;
            host_err <= h1_valid && h1_err;
            if (h1_valid) begin
                if (h1_err) begin
                    host_rdata <= '0;
                end else if (!h1_we) begin
                    host_rdata <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: doc/fpga_text_ram_arbiter.md
FPGA_TEXT_RAM_ARBITER -- requirements
Module: text_ram_arbiter

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per screen.
REQ-003 Parameter DEPTH, default COLS*ROWS (2400), cells in text RAM.
REQ-004 CLK  input  1  pixel clock; sole clock; all state on rising edge.
REQ-005 _RESET  input  1  asynchronous, active-low reset.
REQ-006 VID_REQ  input  1  video fetch request, one-cycle pulse per cell.
REQ-007 VID_X / VID_Y  input  8 / 8  cell column / row; 8'hFF means blank.
REQ-008 VID_VALID  output  1  one-cycle pulse: VID_CHAR/VID_ATTR updated.
REQ-009 VID_CHAR / VID_ATTR  output  8 / 8  fetched cell code / attribute.
REQ-010 HOST_REQ, HOST_WE  input  1, 1  host access request (level), write enable.
REQ-011 HOST_ADDR  input  12  linear cell address; HOST_WDATA input 16 {attr,char}.
REQ-012 HOST_ACK  output  1  one-cycle completion pulse; HOST_ERR output 1 address out of range.
REQ-013 HOST_RDATA  output  16  read data, valid with HOST_ACK.
REQ-014 CLEAR  input  1  pulse starts screen fill; FILL input 16 fill cell value.
REQ-015 BUSY  output  1  high while a fill is in progress.
REQ-016 RAM_ADDR 12, RAM_WE 1, RAM_WDATA 16  outputs  single-port synchronous RAM port; RAM_RDATA 16 input, valid cycle after address.

Function
REQ-017 Exactly one RAM access per cycle; priority: video > fill > host.
REQ-018 Video address = VID_Y*COLS + VID_X, shift-add for COLS=80 (Y<<6 + Y<<4 + X), 12-bit result.
REQ-019 VID_REQ in cycle n: RAM read issued cycle n; VID_CHAR/VID_ATTR registered and VID_VALID high in cycle n+2.
REQ-020 VID_X>=COLS, VID_Y>=ROWS or either 8'hFF: no RAM access; cycle n+2 VID_VALID high, VID_CHAR=8'h20, VID_ATTR=8'h00; slot freed for fill/host.
REQ-021 Host granted in first cycle m with HOST_REQ high, no VID_REQ, state IDLE, no host transfer in flight.
REQ-022 Granted write: RAM_WE=1 cycle m; granted read: RAM_WE=0; HOST_ACK pulse cycle m+2, HOST_RDATA=RAM_RDATA (reads) else unchanged.
REQ-023 HOST_ADDR>=DEPTH: no RAM access, HOST_ACK and HOST_ERR pulse cycle m+2, HOST_RDATA=0.
REQ-024 Maximum one host transfer in flight; HOST_REQ still high in cycle after HOST_ACK is a new transaction; host inputs sampled only at grant.
REQ-025 States IDLE, FILL. IDLE->FILL on CLEAR (BUSY=1 next cycle); FILL: counter 0..DEPTH-1 writes FILL at counter each cycle without VID_REQ; after DEPTH-1 written -> IDLE, BUSY=0 next cycle.
REQ-026 CLEAR in FILL ignored; FILL value sampled on CLEAR; host request pending at CLEAR completes first, new grants wait until IDLE.
REQ-027 Video fetches never delayed by fill or host; simultaneous VID_REQ and host/fill request: video wins, other retried next cycle.
REQ-028 Idle cycles: RAM_WE=0, RAM_ADDR holds last value.

Reset
REQ-029 _RESET low: state IDLE, BUSY=0, counter 0, VID_VALID=0, HOST_ACK=0, HOST_ERR=0, RAM_WE=0, RAM_ADDR=0, VID_CHAR=8'h20, VID_ATTR=0, HOST_RDATA=0, in-flight flags cleared.
REQ-030 Reset mid-fill or mid-transfer aborts; no ACK or VALID issued for aborted operation.

Structure
REQ-031 Shared package/header: state encodings, blank cell constant 16'h0020, address width 12.
REQ-032 One sub-module natural: text_addr_calc (X,Y -> linear address, range flag), combinational.

Verification
REQ-033 VID_REQ X=5,Y=2, RAM[165]=16'h1F41 -> cycle n+2 VID_VALID, CHAR=8'h41, ATTR=8'h1F.
REQ-034 VID_REQ X=8'hFF -> no RAM_WE/read, n+2 CHAR=8'h20, ATTR=0.
REQ-035 Host write ADDR=12'd100, WDATA=16'h0742 during continuous VID_REQ every 8 cycles -> ACK within 9 cycles, then host read returns 16'h0742.
REQ-036 Host ADDR=12'd2400 -> HOST_ERR+ACK, no RAM write, RDATA=0.
REQ-037 CLEAR FILL=16'h0020 with VID_REQ every 8 cycles -> BUSY ~2743 cycles, all 2400 cells=16'h0020, every video fetch on time.
REQ-038 _RESET low at fill counter 1000 -> BUSY=0, cells 1000+ untouched, no ACK.
